// File: rtl/universal_shift_register.sv
// Universal shift register: parallel load, shift, rotate and a counted burst-shift engine.
// Optional parity output is enabled with `define USR_PARITY_EN.
//
// state  | meaning
// IDLE   | free-run: mode applied every edge; start accepted here only
// RUN    | burst: latched op applied every edge, count decremented
// DONE   | q holds for one cycle, done pulse high
module universal_shift_register #(
   parameter int WIDTH = 8,
   parameter int AMT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_l,
   input  logic             sin_r,
   input  logic             start,
   input  logic [AMT_W-1:0] amt,
   output logic [WIDTH-1:0] q,
   output logic             sout_l,
   output logic             sout_r,
   output logic             busy,
   output logic             done
`ifdef USR_PARITY_EN
   ,
   output logic             parity
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [2:0] OP_HOLD = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_SHL  = 3'b010;
   localparam logic [2:0] OP_SHR  = 3'b011;
   localparam logic [2:0] OP_ROTL = 3'b100;
   localparam logic [2:0] OP_ROTR = 3'b101;
   localparam logic [2:0] OP_ASHR = 3'b110;
   localparam logic [2:0] OP_CLR  = 3'b111;

   localparam logic [AMT_W-1:0] CNT_ZERO = '0;
   localparam logic [AMT_W-1:0] CNT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_q_nxt;
   logic [AMT_W-1:0] r_cnt;
   logic [AMT_W-1:0] w_cnt_nxt;
   logic [2:0]       r_op;
   logic [2:0]       w_op_nxt;
   logic             w_mode_is_shift;

   function automatic logic [WIDTH-1:0] f_apply(input logic [2:0] op,
                                                input logic [WIDTH-1:0] v,
                                                input logic [WIDTH-1:0] ld,
                                                input logic sl,
                                                input logic sr);
      logic [WIDTH-1:0] res;
      res = v;
      case (op)
         OP_HOLD: res = v;
         OP_LOAD: res = ld;
         OP_SHL:  res = {v[WIDTH-2:0], sr};
         OP_SHR:  res = {sl, v[WIDTH-1:1]};
         OP_ROTL: res = {v[WIDTH-2:0], v[WIDTH-1]};
         OP_ROTR: res = {v[0], v[WIDTH-1:1]};
         OP_ASHR: res = {v[WIDTH-1], v[WIDTH-1:1]};
         OP_CLR:  res = '0;
         default: res = v;
      endcase
      return res;
   endfunction

   assign w_mode_is_shift = (mode >= OP_SHL) && (mode <= OP_ASHR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_q     <= '0;
         r_cnt   <= '0;
         r_op    <= OP_HOLD;
      end else begin
         r_state <= w_state_nxt;
         r_q     <= w_q_nxt;
         r_cnt   <= w_cnt_nxt;
         r_op    <= w_op_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_q_nxt     = r_q;
      w_cnt_nxt   = r_cnt;
      w_op_nxt    = r_op;
      case (r_state)
         S_IDLE: begin
            if (!start) begin
               w_q_nxt = f_apply(mode, r_q, d, sin_l, sin_r);
            end else if (w_mode_is_shift && (amt != CNT_ZERO)) begin
               w_op_nxt    = mode;
               w_cnt_nxt   = amt;
               w_state_nxt = S_RUN;
            end else begin
               // A zero-length shift leaves q untouched; non-shift modes apply once.
               if (!w_mode_is_shift)
                  w_q_nxt = f_apply(mode, r_q, d, sin_l, sin_r);
               w_state_nxt = S_DONE;
            end
         end
         S_RUN: begin
            w_q_nxt   = f_apply(r_op, r_q, d, sin_l, sin_r);
            w_cnt_nxt = r_cnt - CNT_ONE;
            if (r_cnt == CNT_ONE)
               w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign q      = r_q;
   assign sout_l = r_q[WIDTH-1];
   assign sout_r = r_q[0];
   assign busy   = (r_state == S_RUN);
   assign done   = (r_state == S_DONE);

`ifdef USR_PARITY_EN
   assign parity = ^r_q;
`endif

endmodule
